// File: rtl/exec_pipeline_pkg.sv
// exec_pipeline_pkg: ALU operation codes and the control-field structs
// carried by the EX, MEM and WB stage registers of exec_pipeline.
package exec_pipeline_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD     = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB     = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND     = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR      = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR     = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL     = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL     = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLT     = 4'd7;
  // Canonical "no operation" code; every unlisted code also yields zero.
  localparam logic [ALU_OP_W-1:0] ALU_DEFAULT = 4'd15;

  // Width-independent control fields of the EX stage register.
  typedef struct packed {
    logic                valid;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                reg_wr;
    logic                mem_wr;
    logic                mem_to_reg;
    logic                is_jump;
  } ex_ctrl_t;

  // Control fields of the MEM stage register.
  typedef struct packed {
    logic valid;
    logic reg_wr;
    logic mem_wr;
    logic mem_to_reg;
  } mem_ctrl_t;

  // Control fields of the WB stage register.
  typedef struct packed {
    logic valid;
    logic reg_wr;
    logic mem_to_reg;
  } wb_ctrl_t;

endpackage

// File: rtl/exec_pipeline_if.sv
// exec_pipeline_if: decoded-instruction handshake from fetch/decode plus the
// redirect and retire signals returned by the back end.
interface exec_pipeline_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int PC_W  = 5
);
  localparam int RW = $clog2(NREGS);

  logic            in_valid;
  logic            in_ready;
  logic [PC_W-1:0] in_pc;
  logic [RW-1:0]   in_rs1;
  logic [RW-1:0]   in_rs2;
  logic [RW-1:0]   in_rd;
  logic [XLEN-1:0] in_imm;
  logic [3:0]      in_alu_op;
  logic            in_alu_src;
  logic            in_reg_wr;
  logic            in_mem_wr;
  logic            in_mem_to_reg;
  logic            in_is_jump;

  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            retire_valid;
  logic [RW-1:0]   retire_rd;
  logic [XLEN-1:0] retire_data;

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_imm, in_alu_op,
           in_alu_src, in_reg_wr, in_mem_wr, in_mem_to_reg, in_is_jump,
    input  in_ready, redirect_valid, redirect_pc,
           retire_valid, retire_rd, retire_data
  );

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_imm, in_alu_op,
           in_alu_src, in_reg_wr, in_mem_wr, in_mem_to_reg, in_is_jump,
    output in_ready, redirect_valid, redirect_pc,
           retire_valid, retire_rd, retire_data
  );

endinterface

// File: rtl/exec_alu.sv
// exec_alu: combinational ALU for the EX stage.
module exec_alu
  import exec_pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  input  logic [ALU_OP_W-1:0] op_i,
  output logic [XLEN-1:0]     y_o
);
  localparam int SW = $clog2(XLEN);

  // Operation decode; unknown codes produce zero.
  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLL: y_o = a_i << b_i[SW-1:0];
      ALU_SRL: y_o = a_i >> b_i[SW-1:0];
      ALU_SLT: y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/exec_pipeline.sv
// exec_pipeline: issue/EX/MEM/WB back end with register file, ALU, data
// memory, load-use and dependency stalls and jump redirect.
// Optional feature macro: EXEC_PIPELINE_FWD_EN enables MEM/WB-to-EX operand
// forwarding with a load-use-only stall; without it dependent instructions
// wait until the producer reaches WB.
module exec_pipeline
  import exec_pipeline_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int PC_W       = 5,
  parameter int DMEM_DEPTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  exec_pipeline_if.slave bus
);
  localparam int RW = $clog2(NREGS);
  localparam int AW = $clog2(DMEM_DEPTH);

  ex_ctrl_t        ex_q, ex_d;
  logic [PC_W-1:0] ex_pc_q;
  logic [RW-1:0]   ex_rd_q;
  logic [XLEN-1:0] ex_imm_q, ex_a_q, ex_b_q;

  mem_ctrl_t       mem_q, mem_d;
  logic [RW-1:0]   mem_rd_q;
  logic [XLEN-1:0] mem_res_q, mem_sdata_q;

  wb_ctrl_t        wb_q, wb_d;
  logic [RW-1:0]   wb_rd_q;
  logic [XLEN-1:0] wb_res_q, wb_load_q;

  logic [XLEN-1:0] rf_q   [NREGS];
  logic [XLEN-1:0] dmem_q [DMEM_DEPTH];

  logic            wb_we;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [XLEN-1:0] op_a, op_b, alu_b, alu_y, ex_res;
  logic [PC_W-1:0] pc_plus1;
  logic            jump_ex, hazard, accept;
  logic [AW-1:0]   mem_addr;

  assign wb_we   = wb_q.valid && wb_q.reg_wr && (wb_rd_q != '0);
  assign wb_data = wb_q.mem_to_reg ? wb_load_q : wb_res_q;

  // Issue read; a same-cycle WB write is bypassed so the register file never
  // returns a value that is about to be overwritten.
  always_comb begin
    rs1_data = rf_q[bus.in_rs1];
    rs2_data = rf_q[bus.in_rs2];
    if (wb_we && (wb_rd_q == bus.in_rs1)) rs1_data = wb_data;
    if (wb_we && (wb_rd_q == bus.in_rs2)) rs2_data = wb_data;
    if (bus.in_rs1 == '0) rs1_data = '0;
    if (bus.in_rs2 == '0) rs2_data = '0;
  end

`ifdef EXEC_PIPELINE_FWD_EN
  logic [RW-1:0] ex_rs1_q, ex_rs2_q;
  logic          mem_fwd;

  // Source-register tags of the EX instruction, needed only to match forwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
    end else begin
      ex_rs1_q <= bus.in_rs1;
      ex_rs2_q <= bus.in_rs2;
    end
  end

  assign mem_fwd = mem_q.valid && mem_q.reg_wr && !mem_q.mem_to_reg && (mem_rd_q != '0);

  // Operand select: the younger MEM result overrides WB data, else issue read.
  always_comb begin
    op_a = ex_a_q;
    op_b = ex_b_q;
    if (wb_we && (wb_rd_q == ex_rs1_q)) op_a = wb_data;
    if (wb_we && (wb_rd_q == ex_rs2_q)) op_b = wb_data;
    if (mem_fwd && (mem_rd_q == ex_rs1_q)) op_a = mem_res_q;
    if (mem_fwd && (mem_rd_q == ex_rs2_q)) op_b = mem_res_q;
  end

  // Load data only exists in WB, so a consumer right behind a load waits one cycle.
  assign hazard = ex_q.valid && ex_q.mem_to_reg && (ex_rd_q != '0) &&
                  ((ex_rd_q == bus.in_rs1) || (ex_rd_q == bus.in_rs2));
`else
  assign op_a = ex_a_q;
  assign op_b = ex_b_q;

  // Without forwarding a consumer waits until its producer reaches WB.
  assign hazard = (ex_q.valid && ex_q.reg_wr && (ex_rd_q != '0) &&
                   ((ex_rd_q == bus.in_rs1) || (ex_rd_q == bus.in_rs2))) ||
                  (mem_q.valid && mem_q.reg_wr && (mem_rd_q != '0) &&
                   ((mem_rd_q == bus.in_rs1) || (mem_rd_q == bus.in_rs2)));
`endif

  assign alu_b    = ex_q.alu_src ? ex_imm_q : op_b;
  assign pc_plus1 = ex_pc_q + PC_W'(1);
  assign ex_res   = ex_q.is_jump ? XLEN'(pc_plus1) : alu_y;
  assign jump_ex  = ex_q.valid && ex_q.is_jump;
  assign mem_addr = mem_res_q[AW-1:0];

  exec_alu #(.XLEN(XLEN)) u_alu (
    .a_i  (op_a),
    .b_i  (alu_b),
    .op_i (ex_q.alu_op),
    .y_o  (alu_y)
  );

  // A jump in EX flushes the offered slot; otherwise a hazard holds issue.
  assign bus.in_ready       = !jump_ex && !hazard;
  assign accept             = bus.in_valid && bus.in_ready;
  assign bus.redirect_valid = jump_ex;
  assign bus.redirect_pc    = jump_ex ? (ex_pc_q + ex_imm_q[PC_W-1:0]) : '0;
  assign bus.retire_valid   = wb_q.valid;
  assign bus.retire_rd      = wb_rd_q;
  assign bus.retire_data    = wb_q.valid ? wb_data : '0;

  // Next-state control for all three stage registers; jumps never store.
  always_comb begin
    ex_d            = '0;
    ex_d.valid      = accept;
    ex_d.alu_op     = bus.in_alu_op;
    ex_d.alu_src    = bus.in_alu_src;
    ex_d.reg_wr     = bus.in_reg_wr;
    ex_d.mem_wr     = bus.in_mem_wr;
    ex_d.mem_to_reg = bus.in_mem_to_reg;
    ex_d.is_jump    = bus.in_is_jump;

    mem_d            = '0;
    mem_d.valid      = ex_q.valid;
    mem_d.reg_wr     = ex_q.reg_wr;
    mem_d.mem_wr     = ex_q.mem_wr && !ex_q.is_jump;
    mem_d.mem_to_reg = ex_q.mem_to_reg;

    wb_d            = '0;
    wb_d.valid      = mem_q.valid;
    wb_d.reg_wr     = mem_q.reg_wr;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
  end

  // Stage registers; reset drops every in-flight instruction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      ex_pc_q     <= '0;
      ex_rd_q     <= '0;
      ex_imm_q    <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      mem_q       <= '0;
      mem_rd_q    <= '0;
      mem_res_q   <= '0;
      mem_sdata_q <= '0;
      wb_q        <= '0;
      wb_rd_q     <= '0;
      wb_res_q    <= '0;
    end else begin
      ex_q        <= ex_d;
      ex_pc_q     <= bus.in_pc;
      ex_rd_q     <= bus.in_rd;
      ex_imm_q    <= bus.in_imm;
      ex_a_q      <= rs1_data;
      ex_b_q      <= rs2_data;
      mem_q       <= mem_d;
      mem_rd_q    <= ex_rd_q;
      mem_res_q   <= ex_res;
      mem_sdata_q <= op_b;
      wb_q        <= wb_d;
      wb_rd_q     <= mem_rd_q;
      wb_res_q    <= mem_res_q;
    end
  end

  // Register file write at the end of WB; r0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[wb_rd_q] <= wb_data;
    end
  end

  // Data memory keeps its contents across reset; load data is registered into WB.
  always_ff @(posedge clk) begin
    if (mem_q.valid && mem_q.mem_wr) dmem_q[mem_addr] <= mem_sdata_q;
    wb_load_q <= dmem_q[mem_addr];
  end

endmodule

// File: tb/tb_exec_pipeline.sv
// tb_exec_pipeline: directed, self-checking bench for exec_pipeline.
// Expected stall counts follow EXEC_PIPELINE_FWD_EN when it is defined.
module tb_exec_pipeline;
  import exec_pipeline_pkg::*;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int PC_W       = 5;
  localparam int DMEM_DEPTH = 32;
  localparam int RW         = $clog2(NREGS);

`ifdef EXEC_PIPELINE_FWD_EN
  localparam int DEP_STALL = 0;
  localparam int LU_STALL  = 1;
  localparam int PAIR_GAP  = 1;
`else
  localparam int DEP_STALL = 2;
  localparam int LU_STALL  = 2;
  localparam int PAIR_GAP  = 3;
`endif

  typedef struct packed {
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      op;
    logic            src;
    logic            rw;
    logic            mw;
    logic            m2r;
    logic            jmp;
    logic [PC_W-1:0] pc;
  } instr_t;

  typedef struct {
    int              rd;
    logic [XLEN-1:0] data;
    int              c;
  } ret_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  ret_t retQ[$];

  logic [3:0]      aluOp  [10];
  logic [XLEN-1:0] aluImm [10];
  logic [XLEN-1:0] aluExp [10];

  exec_pipeline_if #(.XLEN(XLEN), .NREGS(NREGS), .PC_W(PC_W)) bus ();

  exec_pipeline #(
    .XLEN(XLEN), .NREGS(NREGS), .PC_W(PC_W), .DMEM_DEPTH(DMEM_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every retirement with the cycle it was seen in
  always @(negedge clk) begin
    if (bus.retire_valid === 1'b1) begin
      ret_t r;
      r.rd   = int'(bus.retire_rd);
      r.data = bus.retire_data;
      r.c    = cyc;
      retQ.push_back(r);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic instr_t mkOp(input int rd, input int rs1, input int rs2,
                                  input logic [XLEN-1:0] imm, input logic [3:0] op,
                                  input logic src, input logic rw, input logic mw,
                                  input logic m2r, input logic jmp, input int pc);
    instr_t i;
    i.rd  = RW'(rd);
    i.rs1 = RW'(rs1);
    i.rs2 = RW'(rs2);
    i.imm = imm;
    i.op  = op;
    i.src = src;
    i.rw  = rw;
    i.mw  = mw;
    i.m2r = m2r;
    i.jmp = jmp;
    i.pc  = PC_W'(pc);
    return i;
  endfunction

  function automatic instr_t mkImm(input int rd, input int rs1, input logic [XLEN-1:0] imm,
                                   input logic [3:0] op);
    return mkOp(rd, rs1, 0, imm, op, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
  endfunction

  function automatic instr_t mkAlu(input int rd, input int rs1, input int rs2,
                                   input logic [3:0] op);
    return mkOp(rd, rs1, rs2, '0, op, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
  endfunction

  function automatic instr_t mkStore(input int rs1, input int rs2, input logic [XLEN-1:0] imm);
    return mkOp(0, rs1, rs2, imm, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
  endfunction

  function automatic instr_t mkLoad(input int rd, input int rs1, input logic [XLEN-1:0] imm);
    return mkOp(rd, rs1, 0, imm, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
  endfunction

  task automatic applyStimulus(input instr_t ins);
    bus.in_valid      = 1'b1;
    bus.in_pc         = ins.pc;
    bus.in_rs1        = ins.rs1;
    bus.in_rs2        = ins.rs2;
    bus.in_rd         = ins.rd;
    bus.in_imm        = ins.imm;
    bus.in_alu_op     = ins.op;
    bus.in_alu_src    = ins.src;
    bus.in_reg_wr     = ins.rw;
    bus.in_mem_wr     = ins.mw;
    bus.in_mem_to_reg = ins.m2r;
    bus.in_is_jump    = ins.jmp;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  // Offer one instruction until accepted (bounded) and check the stall count
  task automatic sendInstr(input instr_t ins, input int expStalls, input string tag);
    int stalls = 0;
    @(negedge clk);
    applyStimulus(ins);
    #1;
    while (bus.in_ready !== 1'b1 && stalls < 8) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    checkOutput({tag, " accepted"}, 64'(bus.in_ready), 64'd1);
    checkOutput({tag, " stall cycles"}, 64'(stalls), 64'(expStalls));
    @(posedge clk);
  endtask

  task automatic findRetire(input int rd, output bit found, output logic [XLEN-1:0] data,
                            output int c);
    int idx = -1;
    found = 1'b0;
    data  = 'x;
    c     = -1;
    foreach (retQ[i]) if (idx < 0 && retQ[i].rd == rd) idx = i;
    if (idx >= 0) begin
      found = 1'b1;
      data  = retQ[idx].data;
      c     = retQ[idx].c;
      retQ.delete(idx);
    end
  endtask

  task automatic checkRetire(input string tag, input int rd, input logic [XLEN-1:0] exp,
                             output int c);
    bit found;
    logic [XLEN-1:0] data;
    findRetire(rd, found, data, c);
    checkOutput({tag, " retired"}, 64'(found), 64'd1);
    checkOutput({tag, " data"}, 64'(data), 64'(exp));
  endtask

  initial begin
    int  c1, c2, cx;
    bit  fnd;
    logic [XLEN-1:0] dummy;

    aluOp  = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
               ALU_SLT, ALU_SLT, ALU_DEFAULT, ALU_ADD};
    aluImm = '{32'h34, 32'h0FF0, 32'h000F, 32'hFFFF, 32'h24, 32'hFFFF_FFE4,
               32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h5, 32'hFFFF_FFFF};
    aluExp = '{32'h1200, 32'h0230, 32'h123F, 32'hEDCB, 32'h12340, 32'h123,
               32'h0, 32'h1, 32'h0, 32'h1233};

    rst = 1'b1;
    applyStimulus(mkImm(0, 0, '0, ALU_ADD));
    bus.in_valid = 1'b0;

    $display("[TB] reset values");
    @(negedge clk);
    #1;
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset redirect_valid", 64'(bus.redirect_valid), 64'd0);
    checkOutput("reset redirect_pc", 64'(bus.redirect_pc), 64'd0);
    checkOutput("reset retire_valid", 64'(bus.retire_valid), 64'd0);
    checkOutput("reset retire_rd", 64'(bus.retire_rd), 64'd0);
    checkOutput("reset retire_data", 64'(bus.retire_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] dependent pair r1=r0+5, r2=r1+r1");
    sendInstr(mkImm(1, 0, 32'd5, ALU_ADD), 0, "r1 producer");
    sendInstr(mkAlu(2, 1, 1, ALU_ADD), DEP_STALL, "r2 consumer");
    idle(6);
    checkRetire("r1", 1, 32'd5, c1);
    checkRetire("r2", 2, 32'd10, c2);
    checkOutput("pair retire gap", 64'(c2 - c1), 64'(PAIR_GAP));

    $display("[TB] load-use: store r1 to mem[3], r3=load, r4=r3+r1");
    sendInstr(mkStore(0, 1, 32'd3), 0, "store mem3");
    sendInstr(mkLoad(3, 0, 32'd3), 0, "load r3");
    sendInstr(mkAlu(4, 3, 1, ALU_ADD), LU_STALL, "r4 load-use");
    idle(6);
    checkRetire("r3 load", 3, 32'd5, cx);
    checkRetire("r4 sum", 4, 32'd10, cx);

    $display("[TB] ALU operations on r8=0x1234");
    sendInstr(mkImm(8, 0, 32'h1234, ALU_ADD), 0, "r8 init");
    idle(4);
    checkRetire("r8", 8, 32'h1234, cx);
    for (int i = 0; i < 10; i++) sendInstr(mkImm(11 + i, 8, aluImm[i], aluOp[i]), 0, "alu op");
    idle(6);
    for (int i = 0; i < 10; i++) checkRetire($sformatf("alu op %0d", i), 11 + i, aluExp[i], cx);

    $display("[TB] address wrap and r0 write");
    sendInstr(mkStore(0, 8, 32'(DMEM_DEPTH + 2)), 0, "store wrap");
    sendInstr(mkLoad(9, 0, 32'd2), 0, "load addr2");
    sendInstr(mkImm(0, 0, 32'd77, ALU_ADD), 0, "write r0");
    sendInstr(mkAlu(10, 0, 0, ALU_ADD), 0, "read r0");
    idle(6);
    checkRetire("wrap load r9", 9, 32'h1234, cx);
    checkRetire("r10 from r0", 10, 32'd0, cx);

    $display("[TB] jump pc=4 imm=6 rd=r5");
    sendInstr(mkStore(0, 4, 32'd5), 0, "store mem5");
    idle(4);
    sendInstr(mkOp(5, 0, 0, 32'd6, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4), 0, "jump");
    @(negedge clk);
    applyStimulus(mkImm(7, 0, 32'd99, ALU_ADD));
    #1;
    checkOutput("jump redirect_valid", 64'(bus.redirect_valid), 64'd1);
    checkOutput("jump redirect_pc", 64'(bus.redirect_pc), 64'd10);
    checkOutput("jump in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checkOutput("redirect one cycle", 64'(bus.redirect_valid), 64'd0);
    idle(5);
    checkRetire("jump link r5", 5, 32'd5, cx);
    findRetire(7, fnd, dummy, cx);
    checkOutput("dropped instr retired", 64'(fnd), 64'd0);
    sendInstr(mkLoad(6, 0, 32'd5), 0, "load mem5");
    idle(5);
    checkRetire("mem5 after jump", 6, 32'd10, cx);

    $display("[TB] reset with instructions in flight");
    sendInstr(mkImm(21, 0, 32'd1, ALU_ADD), 0, "flight a");
    sendInstr(mkOp(22, 0, 0, 32'd3, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7), 0, "flight jump");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    retQ.delete();
    checkOutput("midreset retire_valid", 64'(bus.retire_valid), 64'd0);
    checkOutput("midreset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("midreset redirect_valid", 64'(bus.redirect_valid), 64'd0);
    checkOutput("midreset retire_data", 64'(bus.retire_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    checkOutput("retires after reset", 64'(retQ.size()), 64'd0);
    sendInstr(mkAlu(23, 1, 4, ALU_ADD), 0, "read r1+r4");
    sendInstr(mkImm(24, 8, '0, ALU_ADD), 0, "read r8");
    idle(6);
    checkRetire("r1+r4 after reset", 23, 32'd0, cx);
    checkRetire("r8 after reset", 24, 32'd0, cx);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_pipeline.md
# exec_pipeline

Parametrised execute/memory/writeback back end for the pipelined CPU. It accepts decoded instructions from the fetch/decode stage over a valid/ready handshake and owns the register file, ALU, data memory, forwarding and hazard stalls. It issues jump redirects back to fetch. It replaces the fixed 32-bit, single-forward-path back end with configurable widths and depths, load-use stalling, WB-to-EX forwarding and jump flush.

## Interface
- XLEN, 32, datapath width
- NREGS, 32, register count; RW = $clog2(NREGS); r0 reads as zero
- PC_W, 5, program-counter width
- DMEM_DEPTH, 32, data-memory words; AW = $clog2(DMEM_DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted when in_valid & in_ready at rising edge
- in_pc  in  PC_W  instruction pc
- in_rs1, in_rs2  in  RW  source registers
- in_rd  in  RW  destination register
- in_imm  in  XLEN  immediate
- in_alu_op  in  4  ALU operation
- in_alu_src  in  1  1: operand B = imm
- in_reg_wr  in  1  writes rd
- in_mem_wr  in  1  store rs2 data
- in_mem_to_reg  in  1  load
- in_is_jump  in  1  unconditional jump
- redirect_valid  out  1  jump resolved in EX
- redirect_pc  out  PC_W  jump target
- retire_valid  out  1  WB stage valid
- retire_rd  out  RW  WB destination
- retire_data  out  XLEN  WB write data

## Operation
- Stages: issue (register-file read), EX, MEM, WB. Each stage register holds a valid bit and the stage's control fields.
- Issue read is combinational. A WB write to the same register in the same cycle bypasses into the read.
- ALU ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL: shift amount is B[$clog2(XLEN)-1:0]
  - 7 SLT: signed, zero-extended result
  - all other codes: result 0
- Jump in EX:
  - redirect_valid=1; redirect_pc = pc + imm[PC_W-1:0], modulo 2^PC_W.
  - ALU result is pc+1, zero-extended; it is written to rd if reg_wr.
  - mem_wr is ignored.
  - in_ready=0 that cycle; the offered instruction is dropped and fetch must re-offer from redirect_pc.
- MEM stage:
  - Address = alu_res[AW-1:0], word addressed; it wraps silently.
  - A store writes at the end of MEM.
  - A load reads synchronously; its data is valid in WB.
- Register-file writes happen at the end of WB when reg_wr and rd≠0. Writes to r0 are discarded.
- Operand forwarding for EX (compiled with the forwarding macro, see Configuration):
  - Priority 1: MEM-stage ALU result, if MEM is valid, reg_wr, !mem_to_reg, rd≠0 and rd matches the source.
  - Priority 2: WB data, under the same match conditions.
  - Otherwise: the issue-read value.
- Load-use stall: in_ready=0 while EX holds a valid load with rd≠0 equal to in_rs1 or in_rs2. Both sources are compared regardless of use. EX takes a bubble in the next cycle.
- Priority when events coincide: reset > jump flush > stall.
- Reset:
  - Clears all stage valids and the register file.
  - Data memory is not reset.
  - Output reset values: in_ready=1, redirect_valid=0, redirect_pc=0, retire_valid=0, retire_rd=0, retire_data=0.

## Timing
- An instruction accepted at edge E0 is in EX during cycle E0–E1, MEM during E1–E2 and WB during E2–E3. retire_valid is high during E2–E3 and the register is written at E3.
- Throughput: 1 instruction/cycle with no hazards.
- Penalties: load-use costs 1 stall cycle; a jump costs 1 lost issue slot.
- redirect_valid, redirect_pc and in_ready are combinational from stage registers and inputs. No output depends combinationally on in_valid.
- Reset asserted mid-operation discards all in-flight instructions immediately; nothing retires afterwards.

## Configuration
- EXEC_PIPELINE_FWD_EN defined: the forwarding paths and load-use stall rule described above are used.
- EXEC_PIPELINE_FWD_EN undefined:
  - No EX forwarding.
  - in_ready=0 while EX or MEM holds a valid reg_wr instruction with rd≠0 matching in_rs1 or in_rs2.
  - The WB write-through bypass remains.
  - A dependent instruction stalls up to 2 cycles.

## Structure
- exec_pipeline_pkg holds:
  - ALU op localparams, including the default code
  - stage-register struct typedefs for EX, MEM and WB
- Sub-module exec_alu: combinational, parametrised by XLEN.
- The register file and data memory are inline arrays.

## Test plan
- Reset: pulse rst with instructions in flight → retire_valid=0, in_ready=1, redirect_valid=0, all registers read 0; no retire afterwards.
- Forwarding (FWD_EN): r1=r0+5 (imm), then r2=r1+r1 back-to-back → in_ready stays 1; r2 retires 10 one cycle after r1 retires 5.
- Load-use: store r1 (5) to mem[3]; r3=load mem[3]; r4=r3+r1 → in_ready low exactly 1 cycle; r4=10.
- Jump: pc=4, imm=6, rd=r5, reg_wr → redirect_valid 1 cycle with redirect_pc=10; r5=5; the instruction offered in that cycle is not accepted.
- No forwarding (macro undefined): same dependent pair as the forwarding test → in_ready low 2 cycles; r2=10.
- Wrap: a store to address DMEM_DEPTH+2 followed by a load from address 2 returns the stored value; a write to r0 leaves r0 reading 0.
